matrix_loader: RTL and testbench

MATRIX_LOADER -- requirements
Module: matrix_loader

---
 rtl/matrix_loader.sv | 144 ++++++++++++++
 tb/tb_matrix_loader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - collects a 2x2 or 3x3 signed matrix from a stream and presents it packed
//
// Purpose: accepts matrix elements in row-major order over a valid/ready
// handshake, places them into a packed N*N slot array (slot k = 3*row + col,
// slot 0 in the top bits), and holds the finished matrix for the determinant
// stage until it is consumed. A 2x2 load is embedded in the 3x3 frame with
// slot 8 set to +1 so both orders share one determinant datapath.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      begin (or restart) a load
//   sz3        order select latched on start: 1 = 3x3, 0 = 2x2
//   in_data    signed element, row-major
//   in_valid   in_data valid this cycle
//   in_ready   loader accepts in_data this cycle
//   matrix     packed signed matrix, N*N*ELEM_W bits
//   mat_valid  matrix complete and stable
//   mat_ready  downstream consumes matrix this cycle
//   count      elements accepted in the current load
//   busy       loader is in LOAD or DONE

module matrix_loader #(
    parameter int ELEM_W = 8,
    parameter int N      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      sz3,
    input  logic [ELEM_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [N*N*ELEM_W-1:0]     matrix,
    output logic                      mat_valid,
    input  logic                      mat_ready,
    output logic [3:0]                count,
    output logic                      busy
);

    localparam int NN = N * N;
    localparam int MW = NN * ELEM_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_sz3;
    logic [3:0]      r_count;
    logic [MW-1:0]   r_matrix;

    logic            w_restart;
    logic            w_accept;
    logic            w_last;
    logic [3:0]      w_slot;
    logic [MW-1:0]   w_template;

    // start is honoured everywhere except DONE, where it only counts when
    // the matrix is being consumed on the same cycle.
    assign w_restart = start && ((r_state != S_DONE) || mat_ready);

    // An element on a restart cycle is dropped: the restart wins.
    assign w_accept  = (r_state == S_LOAD) && in_valid && !start;

    assign w_last    = r_sz3 ? (r_count == 4'd8) : (r_count == 4'd3);

    // 2x2 element i lands at row i/2, col i%2 of the 3x3 frame: 0,1,3,4.
    always_comb begin
        w_slot = r_count;
        if (!r_sz3) begin
            w_slot = (r_count[1] ? 4'(N) : 4'd0) + {3'b000, r_count[0]};
        end
    end

    // Template uses the incoming sz3 because it is latched on the same edge.
    always_comb begin
        w_template = '0;
        if (!sz3) begin
            w_template[ELEM_W-1:0] = ELEM_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (start)                 w_next = S_LOAD;
                else if (w_accept && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (mat_ready) w_next = start ? S_LOAD : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from state only
    always_comb begin
        in_ready  = (r_state == S_LOAD);
        mat_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
    end

    // Datapath: order latch, element counter and packed slot array
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sz3    <= 1'b0;
            r_count  <= 4'd0;
            r_matrix <= '0;
        end else if (w_restart) begin
            r_sz3    <= sz3;
            r_count  <= 4'd0;
            r_matrix <= w_template;
        end else if (w_accept) begin
            r_count <= r_count + 4'd1;
            for (int k = 0; k < NN; k++) begin
                if (w_slot == 4'(k)) begin
                    r_matrix[(NN-1-k)*ELEM_W +: ELEM_W] <= in_data;
                end
            end
        end
    end

    assign matrix = r_matrix;
    assign count  = r_count;

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - directed and randomized self-checking bench for matrix_loader

module tb_matrix_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sz3;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] matrix;
    logic        mat_valid;
    logic        mat_ready;
    logic [3:0]  count;
    logic        busy;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: phase of the transaction plus the list of elements
    // received in the current load; the packed image is derived from them.
    int          m_phase;      // 0 idle, 1 collecting, 2 holding result
    logic        m_sz3;
    logic [7:0]  m_elems[$];
    logic [71:0] m_mat;

    matrix_loader #(.ELEM_W(8), .N(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sz3       (sz3),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .matrix    (matrix),
        .mat_valid (mat_valid),
        .mat_ready (mat_ready),
        .count     (count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [71:0] pack(input logic order3, input logic [7:0] e[$]);
        logic [71:0] r;
        int slot;
        r = '0;
        if (!order3) r[7:0] = 8'd1;
        foreach (e[i]) begin
            slot = order3 ? i : (i / 2) * 3 + (i % 2);
            r[(8 - slot) * 8 +: 8] = e[i];
        end
        return r;
    endfunction

    task automatic m_begin(input logic s);
        m_phase = 1;
        m_sz3   = s;
        m_elems = {};
        m_mat   = pack(m_sz3, m_elems);
    endtask

    // One clock: apply inputs, advance the model, compare all outputs.
    task automatic cyc(input logic r, input logic st, input logic s3,
                       input logic v, input logic [7:0] d, input logic mr);
        rst = r; start = st; sz3 = s3; in_valid = v; in_data = d; mat_ready = mr;
        @(posedge clk);
        if (r) begin
            m_phase = 0;
            m_elems = {};
            m_mat   = '0;
        end else begin
            case (m_phase)
                0: if (st) m_begin(s3);
                1: begin
                    if (st) m_begin(s3);
                    else if (v) begin
                        m_elems.push_back(d);
                        m_mat = pack(m_sz3, m_elems);
                        if (m_elems.size() == (m_sz3 ? 9 : 4)) m_phase = 2;
                    end
                end
                default: if (mr) begin
                    if (st) m_begin(s3);
                    else m_phase = 0;
                end
            endcase
        end
        #1;
        check("matrix",    matrix,    m_mat);
        check("count",     72'(count), 72'(m_elems.size()));
        check("in_ready",  72'(in_ready),  72'(m_phase == 1));
        check("mat_valid", 72'(mat_valid), 72'(m_phase == 2));
        check("busy",      72'(busy),      72'(m_phase != 0));
    endtask

    logic [7:0] seq_a[9] = '{8'd1, 8'd2, 8'd2, 8'd0, 8'd4, 8'd1, 8'd3, 8'd5, 8'd1};
    logic [7:0] seq_b[4] = '{8'd3, 8'd1, 8'd2, 8'd4};
    logic [7:0] seq_c[9] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd1};

    initial begin
        m_phase = 0; m_sz3 = 0; m_elems = {}; m_mat = '0;

        // reset state
        cyc(1, 1, 1, 1, 8'hAA, 1);
        cyc(1, 0, 0, 0, 8'h00, 0);
        check("rst_matrix", matrix, 72'h0);
        check("rst_count",  72'(count), 72'h0);

        // 3x3 load, consecutive elements
        cyc(0, 1, 1, 0, 8'h00, 0);
        foreach (seq_a[i]) cyc(0, 0, 0, 1, seq_a[i], 1);
        check("det3_matrix", matrix, 72'h010202000401030501);
        check("det3_valid",  72'(mat_valid), 72'h1);
        cyc(0, 0, 0, 0, 8'h00, 1);
        check("det3_pulse",  72'(mat_valid), 72'h0);

        // 2x2 load
        cyc(0, 1, 0, 0, 8'h00, 0);
        foreach (seq_b[i]) cyc(0, 0, 0, 1, seq_b[i], 0);
        check("det2_matrix", matrix, 72'h030100020400000001);
        check("det2_count",  72'(count), 72'h4);

        // backpressure: start ignored while held, in_valid/in_data toggling
        for (int i = 0; i < 5; i++) cyc(0, i[0], 1, ~i[0], 8'($urandom), 0);
        check("bp_matrix", matrix, 72'h030100020400000001);
        cyc(0, 1, 1, 1, 8'h77, 1);
        check("bp_restart_count", 72'(count), 72'h0);
        check("bp_restart_ready", 72'(in_ready), 72'h1);

        // gaps: valid low on alternate cycles
        foreach (seq_c[i]) begin
            cyc(0, 0, 0, 0, 8'($urandom), 1);
            cyc(0, 0, 0, 1, seq_c[i], 1);
        end
        check("gap_matrix", matrix, 72'h010203000101020201);
        cyc(0, 0, 0, 0, 8'h00, 1);

        // abort after 4 elements, element on the restart cycle dropped
        cyc(0, 1, 1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 8'(i + 9), 0);
        cyc(0, 1, 1, 1, 8'h5A, 0);
        check("abort_count",  72'(count), 72'h0);
        check("abort_matrix", matrix, 72'h0);
        foreach (seq_a[i]) cyc(0, 0, 0, 1, seq_a[i], 0);
        check("abort_reload", matrix, 72'h010202000401030501);
        cyc(0, 0, 0, 0, 8'h00, 1);

        // reset mid-load
        cyc(0, 1, 1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 8'(i + 1), 0);
        cyc(1, 1, 1, 1, 8'hFF, 1);
        check("rst_mid_matrix", matrix, 72'h0);
        check("rst_mid_busy",   72'(busy), 72'h0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 8'(i), 1);
        check("rst_no_valid", 72'(mat_valid), 72'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 19) == 0),
                1'($urandom),
                ($urandom_range(0, 3) != 0),
                8'($urandom),
                ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
